// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave front end issuing single-beat SRAM requests.
module ahb_sram_slave_if #(
  parameter int MEM_BYTES   = 2048,
  parameter int ACK_TIMEOUT = 16,
  parameter int AHB_DWIDTH  = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  output logic [2:0]            ahbsram_size,
  output logic [19:0]           ahbsram_addr,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
  input  logic                  BUSY
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
  logic [2:0] state, nxt;
  logic [7:0] cnt;
  logic [AHB_DWIDTH-1:0] rdata_q;
  logic ack, open, cap, bad, tmo, unused_bits;
  assign unused_bits = ^{HADDR[31:20], HTRANS[0]};
  assign ack = state == S_WAIT & sramahb_ack;
  // only sample a new address phase while our own data phase is completing
  assign open = state == S_IDLE | state == S_ERR2 | ack;
  assign cap = open & HSEL & HREADYIN & HTRANS[1];
  assign bad = HSIZE > 3'd2 | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0])
             | HADDR[19:0] >= 20'(MEM_BYTES);
  assign tmo = cnt == 8'(ACK_TIMEOUT - 1);
  always_comb
    nxt = cap ? (bad ? S_ERR1 : S_REQ)
        : state == S_REQ ? (tmo ? S_ERR1 : BUSY ? S_REQ : S_WAIT)
        : state == S_WAIT ? (ack ? S_IDLE : tmo ? S_ERR1 : S_WAIT)
        : state == S_ERR1 ? S_ERR2 : S_IDLE;
  assign HREADYOUT = open;
  assign HRESP = state == S_ERR1 | state == S_ERR2;
  assign ahbsram_req = state == S_REQ & !BUSY & !tmo;
  assign ahbsram_wdata = HWDATA;
  assign HRDATA = ack ? sramahb_rdata : rdata_q;
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state <= S_IDLE;
      cnt <= '0;
      rdata_q <= '0;
      ahbsram_addr <= '0;
      ahbsram_size <= '0;
      ahbsram_write <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (cap & !bad) ? '0 : (state == S_REQ | state == S_WAIT) ? cnt + 8'd1 : cnt;
      if (ack) rdata_q <= sramahb_rdata;
      if (cap) begin
        ahbsram_addr <= HADDR[19:0];
        ahbsram_size <= HSIZE;
        ahbsram_write <= HWRITE;
      end
    end
endmodule

// File: doc/ahb_sram_slave_if.md
Name: ahb_sram_slave_if

Overview:
- AHB-Lite slave front end that decodes bus transfers and initiates single-beat requests on the SRAM control request/ack interface (ahbsram_* out, sramahb_* in).
- Sits between the fabric AHB-Lite bus and the SRAM controller.
- Owns address-phase capture, wait-state insertion, alignment/range/timeout error responses, and request retry while the RAM reports BUSY.

Parameters:
- MEM_BYTES, 2048, addressable bytes; any captured HADDR[19:0] >= MEM_BYTES gets an ERROR response.
- ACK_TIMEOUT, 16, cycles allowed in S_REQ+S_WAIT before an ERROR response; legal range 4..255.
- AHB_DWIDTH, 32, data width; only 32 is supported.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  reset
- HSEL  in  1  slave select
- HTRANS  in  2  transfer type
- HADDR  in  32  address
- HSIZE  in  3  transfer size
- HWRITE  in  1  write/read
- HWDATA  in  32  write data (data phase)
- HREADYIN  in  1  bus HREADY
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- ahbsram_req  out  1  single-cycle request pulse
- ahbsram_write  out  1  1=write
- ahbsram_wdata  out  32  write data
- ahbsram_size  out  3  captured HSIZE
- ahbsram_addr  out  20  captured HADDR[19:0]
- sramahb_ack  in  1  one-cycle completion strobe
- sramahb_rdata  in  32  read data, valid in the sramahb_ack cycle
- BUSY  in  1  RAM busy; no request may be issued while high

Interface decision: one clock; reset is synchronous and active-high. Clock is HCLK, reset is HRESET.

Behaviour:
- Address sampling:
  - Capture when HSEL & HREADYIN & HTRANS[1] at a rising HCLK edge.
  - Captured fields: HADDR[19:0], HSIZE, HWRITE.
  - IDLE or BUSY transfer types get a zero-wait OKAY response; nothing is captured.
- Error check at capture:
  - HSIZE > 3'b010 is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - Address >= MEM_BYTES is an error.
  - Error goes to S_ERR1; otherwise go to S_REQ.
- States:
  - S_IDLE: HREADYOUT=1, HRESP=0.
  - S_REQ:
    - HREADYOUT=0.
    - ahbsram_req = !BUSY, combinational; the request is issued in exactly one cycle.
    - When !BUSY, go to S_WAIT.
    - ahbsram_wdata = HWDATA, passed through; it is stable because HREADYOUT is low.
  - S_WAIT:
    - HREADYOUT = sramahb_ack; HRDATA = sramahb_rdata.
    - On ack, return to S_IDLE, or to S_REQ/S_ERR1 if a new valid address phase is sampled on the same edge.
  - S_ERR1: HREADYOUT=0, HRESP=1. Then go to S_ERR2.
  - S_ERR2:
    - HREADYOUT=1, HRESP=1.
    - An address phase sampled in this cycle is accepted as normal.
- Nominal latency, with BUSY low and the controller acking 2 cycles after req:
  - T0 address phase.
  - T1 S_REQ, req=1.
  - T2 S_WAIT.
  - T3 ack, HREADYOUT=1.
  - Result: 2 wait states for both read and write.
- Back-to-back transfers: the next address phase overlaps the completing data phase. No idle cycle is required between transfers.
- Timeout:
  - An 8-bit counter clears on entry to S_REQ and increments each cycle in S_REQ/S_WAIT.
  - Reaching ACK_TIMEOUT without ack: go to S_ERR1 and drop req.
  - A late ack arriving in S_IDLE/S_ERR* is ignored.
- Output hold rules:
  - HRDATA holds its last ack value outside ack cycles.
  - ahbsram_addr/size/write hold their captured values until the next capture.
- Reset (synchronous, HRESET=1 at an edge), including mid-transfer:
  - State goes to S_IDLE; HREADYOUT=1; HRESP=0; ahbsram_req=0.
  - ahbsram_addr=0, ahbsram_size=0, ahbsram_write=0; HRDATA=0; counter=0.
- An ack arriving while not in S_WAIT has no effect.
- Unlisted HTRANS/HSEL combinations while HREADYIN=0 are ignored.

Test Plan:
- Word write then read, with HRESET pulsed for 2 cycles first:
  - Stimulus: write HADDR=0x0000_0010, HWDATA=0xDEADBEEF, HSIZE=2; then read 0x10.
  - Required: ahbsram_req high exactly 1 cycle per transfer; HREADYOUT low 2 cycles each; HRDATA=0xDEADBEEF with OKAY.
- Back-to-back pipelined transfers:
  - Stimulus: halfword writes to 0x02 and 0x04 issued with no idle cycle.
  - Required: two req pulses, ahbsram_addr sequence 0x02 then 0x04, total 6 data-phase cycles.
- Errors:
  - Stimulus: word access at 0x01, then HSIZE=3, then address 0x800 with MEM_BYTES=2048.
  - Required for each: no req; HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
- BUSY retry:
  - Stimulus: BUSY held high 3 cycles during S_REQ.
  - Required: req stays 0 for those cycles, then pulses once when BUSY falls; transfer completes OKAY.
- Timeout:
  - Stimulus: sramahb_ack held at 0, ACK_TIMEOUT=16.
  - Required: ERROR response begins 16 cycles after S_REQ entry; a later stray ack is ignored; the next read completes normally.
- Reset mid-transfer:
  - Stimulus: HRESET asserted in S_WAIT.
  - Required: next cycle HREADYOUT=1, HRESP=0, req=0, HRDATA=0; an ack arriving after reset does not change outputs.
